// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access stage.
package mem_access_unit_pkg;

    localparam int DATA_W        = 8;
    localparam int RADDR_W       = 2;
    localparam int TIMEOUT_LIMIT = 15;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic [RADDR_W-1:0] rd;
        logic               reg_write;
        logic               mem_to_reg;
        logic               we;
    } mem_op_t;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Wait-cycle counter: counts un-acked WAIT cycles and flags the cycle that reaches the limit.
module mem_wait_timer
    import mem_access_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Fires on the cycle whose increment would land on the limit.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes ALU ops through, runs loads/stores as a blocking IDLE->WAIT->DONE handshake.
//   state | meaning
//   IDLE  | pass EX through; a load/store is latched and stalls the pipe
//   WAIT  | request driven to data memory until ack or timeout
//   DONE  | present latched op and captured data for one cycle
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  EX_alu_result,
    input  logic [DATA_W-1:0]  EX_store_data,
    input  logic [RADDR_W-1:0] EX_rd,
    input  logic               EX_reg_write,
    input  logic               EX_mem_to_reg,
    input  logic               EX_mem_write,
    output logic [DATA_W-1:0]  MEM_alu_result,
    output logic [DATA_W-1:0]  MEM_mem_data,
    output logic [RADDR_W-1:0] MEM_rd,
    output logic               MEM_reg_write,
    output logic               MEM_mem_to_reg,
    output logic               mem_stall,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               mem_err
);

    state_e            state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;
    logic ex_mem_op;

    assign ex_mem_op   = EX_mem_to_reg | EX_mem_write;
    assign timer_clear = (state_q != WAIT);
    assign timer_en    = (state_q == WAIT) && !dmem_ack;
    assign mem_err     = err_q;

    mem_wait_timer u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        data_d         = data_q;
        err_d          = err_q;
        MEM_alu_result = '0;
        MEM_mem_data   = '0;
        MEM_rd         = '0;
        MEM_reg_write  = 1'b0;
        MEM_mem_to_reg = 1'b0;
        mem_stall      = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;

        case (state_q)
            IDLE: begin
                MEM_alu_result = EX_alu_result;
                MEM_rd         = EX_rd;
                MEM_reg_write  = EX_reg_write;
                MEM_mem_to_reg = EX_mem_to_reg;
                mem_stall      = ex_mem_op;
                if (ex_mem_op) begin
                    op_d.addr       = EX_alu_result;
                    op_d.wdata      = EX_store_data;
                    op_d.rd         = EX_rd;
                    op_d.reg_write  = EX_reg_write;
                    op_d.mem_to_reg = EX_mem_to_reg;
                    op_d.we         = EX_mem_write;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                // MEM_* stay zero here so the stalled cycle reaches MEM/WB as a bubble.
                mem_stall  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = op_q.we;
                dmem_addr  = op_q.addr;
                dmem_wdata = op_q.wdata;
                if (dmem_ack) begin
                    data_d  = op_q.mem_to_reg ? dmem_rdata : '0;
                    state_d = DONE;
                end else if (timer_expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                MEM_alu_result = op_q.addr;
                MEM_mem_data   = data_q;
                MEM_rd         = op_q.rd;
                MEM_reg_write  = op_q.reg_write;
                MEM_mem_to_reg = op_q.mem_to_reg;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus directed scenarios.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] EX_alu_result;
    logic [7:0] EX_store_data;
    logic [1:0] EX_rd;
    logic       EX_reg_write;
    logic       EX_mem_to_reg;
    logic       EX_mem_write;
    logic [7:0] MEM_alu_result;
    logic [7:0] MEM_mem_data;
    logic [1:0] MEM_rd;
    logic       MEM_reg_write;
    logic       MEM_mem_to_reg;
    logic       mem_stall;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic       mem_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .EX_alu_result  (EX_alu_result),
        .EX_store_data  (EX_store_data),
        .EX_rd          (EX_rd),
        .EX_reg_write   (EX_reg_write),
        .EX_mem_to_reg  (EX_mem_to_reg),
        .EX_mem_write   (EX_mem_write),
        .MEM_alu_result (MEM_alu_result),
        .MEM_mem_data   (MEM_mem_data),
        .MEM_rd         (MEM_rd),
        .MEM_reg_write  (MEM_reg_write),
        .MEM_mem_to_reg (MEM_mem_to_reg),
        .mem_stall      (mem_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .mem_err        (mem_err)
    );

    task automatic tally(input string name, input bit ok, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tally(name, act === exp, int'(act), int'(exp));
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        tally(name, act === exp, int'(act), int'(exp));
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tally(name, act === exp, int'(act), int'(exp));
    endtask

    // Transaction model: an op is pending for a number of request cycles,
    // then its result is shown for exactly one cycle.
    bit         m_pending;
    bit         m_show;
    bit         m_err;
    int         m_cycles;
    logic [7:0] m_addr, m_wdata, m_data;
    logic [1:0] m_rd;
    bit         m_rw, m_m2r, m_we;

    always @(posedge clk) begin
        if (reset) begin
            m_pending = 1'b0;
            m_show    = 1'b0;
            m_err     = 1'b0;
            m_data    = 8'h00;
        end else if (m_show) begin
            m_show = 1'b0;
        end else if (m_pending) begin
            if (dmem_ack) begin
                m_data    = m_m2r ? dmem_rdata : 8'h00;
                m_pending = 1'b0;
                m_show    = 1'b1;
            end else if (m_cycles == 15) begin
                m_data    = 8'h00;
                m_err     = 1'b1;
                m_pending = 1'b0;
                m_show    = 1'b1;
            end else begin
                m_cycles++;
            end
        end else if (EX_mem_to_reg || EX_mem_write) begin
            m_addr    = EX_alu_result;
            m_wdata   = EX_store_data;
            m_rd      = EX_rd;
            m_rw      = EX_reg_write;
            m_m2r     = EX_mem_to_reg;
            m_we      = EX_mem_write;
            m_pending = 1'b1;
            m_cycles  = 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_alu, e_data, e_addr, e_wdata;
        logic [1:0] e_rd;
        logic       e_rw, e_m2r, e_stall, e_req, e_we;
        if (chk_en) begin
            e_alu = 8'h00; e_data = 8'h00; e_rd = 2'd0; e_rw = 1'b0; e_m2r = 1'b0;
            e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
            if (m_pending) begin
                e_stall = 1'b1;
                e_req   = 1'b1;
                e_we    = m_we;
                e_addr  = m_addr;
                e_wdata = m_wdata;
            end else if (m_show) begin
                e_alu  = m_addr;
                e_data = m_data;
                e_rd   = m_rd;
                e_rw   = m_rw;
                e_m2r  = m_m2r;
            end else begin
                e_alu   = EX_alu_result;
                e_rd    = EX_rd;
                e_rw    = EX_reg_write;
                e_m2r   = EX_mem_to_reg;
                e_stall = EX_mem_to_reg | EX_mem_write;
            end
            chk8("mdl_MEM_alu_result", MEM_alu_result, e_alu);
            chk8("mdl_MEM_mem_data", MEM_mem_data, e_data);
            chk2("mdl_MEM_rd", MEM_rd, e_rd);
            chk1("mdl_MEM_reg_write", MEM_reg_write, e_rw);
            chk1("mdl_MEM_mem_to_reg", MEM_mem_to_reg, e_m2r);
            chk1("mdl_mem_stall", mem_stall, e_stall);
            chk1("mdl_dmem_req", dmem_req, e_req);
            chk1("mdl_dmem_we", dmem_we, e_we);
            chk8("mdl_dmem_addr", dmem_addr, e_addr);
            chk8("mdl_dmem_wdata", dmem_wdata, e_wdata);
            chk1("mdl_mem_err", mem_err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [7:0] a, input logic [7:0] d, input logic [1:0] r,
                          input logic rw, input logic m2r, input logic mw);
        EX_alu_result = a;
        EX_store_data = d;
        EX_rd         = r;
        EX_reg_write  = rw;
        EX_mem_to_reg = m2r;
        EX_mem_write  = mw;
    endtask

    initial begin
        int reqs;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 8'h00;
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_en = 1'b1;
        step();
        chk1("rst_err", mem_err, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_req", dmem_req, 1'b0);
        reset = 1'b0;

        // ALU pass-through
        set_ex(8'h5A, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
        #2;
        chk8("alu_result", MEM_alu_result, 8'h5A);
        chk2("alu_rd", MEM_rd, 2'd2);
        chk8("alu_mem_data", MEM_mem_data, 8'h00);
        chk1("alu_stall", mem_stall, 1'b0);
        step();

        // Load with immediate ack
        set_ex(8'h10, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0);
        #2;
        chk1("ld_idle_stall", mem_stall, 1'b1);
        chk1("ld_idle_req", dmem_req, 1'b0);
        step();
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 8'hC3;
        #2;
        chk1("ld_wait_req", dmem_req, 1'b1);
        chk8("ld_wait_addr", dmem_addr, 8'h10);
        chk1("ld_wait_stall", mem_stall, 1'b1);
        step();
        dmem_ack = 1'b0; dmem_rdata = 8'h00;
        #2;
        chk1("ld_done_stall", mem_stall, 1'b0);
        chk1("ld_done_req", dmem_req, 1'b0);
        chk8("ld_done_data", MEM_mem_data, 8'hC3);
        chk1("ld_done_m2r", MEM_mem_to_reg, 1'b1);
        chk2("ld_done_rd", MEM_rd, 2'd1);
        step();
        #2;
        chk1("ld_after_req", dmem_req, 1'b0);

        // Store acked on the 3rd WAIT cycle; EX changes while waiting
        set_ex(8'h20, 8'h7E, 2'd0, 1'b0, 1'b0, 1'b1);
        #2;
        chk1("st_idle_stall", mem_stall, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_ex(8'hFF, 8'h11, 2'd3, 1'b1, 1'b0, 1'b0);
            dmem_ack = (i == 2);
            #2;
            chk1("st_wait_we", dmem_we, 1'b1);
            chk8("st_wait_addr", dmem_addr, 8'h20);
            chk8("st_wait_wdata", dmem_wdata, 8'h7E);
            step();
        end
        dmem_ack = 1'b0;
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk1("st_done_rw", MEM_reg_write, 1'b0);
        chk1("st_done_err", mem_err, 1'b0);
        chk1("st_done_req", dmem_req, 1'b0);
        step();

        // Stray ack while idle
        dmem_ack = 1'b1; dmem_rdata = 8'h55;
        #2;
        chk1("idle_ack_stall", mem_stall, 1'b0);
        step();
        step();
        dmem_ack = 1'b0;

        // Ack on the 15th WAIT cycle beats the timeout
        set_ex(8'h30, 8'h00, 2'd3, 1'b1, 1'b1, 1'b0);
        step();
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            dmem_ack   = (i == 15);
            dmem_rdata = (i == 15) ? 8'h99 : 8'h00;
            #2;
            chk1("late_ack_req", dmem_req, 1'b1);
            step();
        end
        dmem_ack = 1'b0;
        #2;
        chk8("late_ack_data", MEM_mem_data, 8'h99);
        chk1("late_ack_err", mem_err, 1'b0);
        step();

        // Reset in the 2nd WAIT cycle, ack arrives afterwards
        set_ex(8'h40, 8'h00, 2'd2, 1'b1, 1'b1, 1'b0);
        step();
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        #2;
        chk1("midrst_req_before", dmem_req, 1'b1);
        step();
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 8'hAA;
        #2;
        chk1("midrst_req_after", dmem_req, 1'b0);
        chk1("midrst_stall", mem_stall, 1'b0);
        step();
        dmem_ack = 1'b0;
        #2;
        chk8("midrst_no_done", MEM_mem_data, 8'h00);
        chk1("midrst_err", mem_err, 1'b0);
        chk1("midrst_req_idle", dmem_req, 1'b0);
        step();

        // Timeout: no ack ever
        set_ex(8'h50, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        reqs = 0;
        for (int i = 0; i < 15; i++) begin
            #2;
            reqs += int'(dmem_req);
            step();
        end
        chk8("to_req_cycles", 8'(reqs), 8'd15);
        #2;
        chk1("to_done_req", dmem_req, 1'b0);
        chk8("to_done_data", MEM_mem_data, 8'h00);
        chk1("to_done_err", mem_err, 1'b1);
        step();
        set_ex(8'h12, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        #2;
        chk1("to_err_sticky", mem_err, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        chk1("to_err_cleared", mem_err, 1'b0);
        step();

        // Back-to-back loads with ack held high
        set_ex(8'h60, 8'h00, 2'd2, 1'b1, 1'b1, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 8'h3C;
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            #2;
            reqs += int'(dmem_req);
            step();
        end
        chk8("b2b_req_cycles", 8'(reqs), 8'd2);
        dmem_ack = 1'b0;
        set_ex(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port EX_alu_result  in  8  ALU result; byte address for memory ops.
REQ-004 SHALL have port EX_store_data  in  8  store data.
REQ-005 SHALL have port EX_rd  in  2  destination register.
REQ-006 SHALL have port EX_reg_write  in  1  register write enable.
REQ-007 SHALL have port EX_mem_to_reg  in  1  load op.
REQ-008 SHALL have port EX_mem_write  in  1  store op; never asserted together with EX_mem_to_reg.
REQ-009 SHALL have ports MEM_alu_result (8), MEM_mem_data (8), MEM_rd (2), MEM_reg_write (1), MEM_mem_to_reg (1), all out; these feed the MEM/WB register.
REQ-010 SHALL have port mem_stall  out  1  holds IF/ID/EX and EX/MEM when high.
REQ-011 SHALL have ports dmem_req (1), dmem_we (1), dmem_addr (8), dmem_wdata (8), all out; data-memory request.
REQ-012 SHALL have ports dmem_rdata  in  8  and dmem_ack  in  1; memory response.
REQ-013 SHALL have port mem_err  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-015 IDLE, no mem op: MEM_* SHALL pass EX_* through combinationally, with MEM_mem_data=0 and mem_stall=0.
REQ-016 IDLE, load or store: SHALL assert mem_stall, latch address, wdata, rd, reg_write, mem_to_reg and we on the edge, then go to WAIT.
REQ-017 WAIT: registered dmem_req=1, with dmem_addr/dmem_wdata/dmem_we held at latched values; mem_stall=1.
REQ-018 WAIT with dmem_ack=1: SHALL capture dmem_rdata (loads) or 0 (stores) into a data register and go to DONE on the same edge.
REQ-019 DONE: dmem_req=0 and mem_stall=0; MEM_* SHALL come from latched copies and MEM_mem_data from the data register; unconditional transition to IDLE.
REQ-020 Minimum memory-op latency SHALL be 3 cycles (IDLE, WAIT with immediate ack, DONE).
REQ-021 A 4-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack.
REQ-022 Counter reaching 15 with no ack: SHALL go to DONE with MEM_mem_data=0x00 and set mem_err.
REQ-023 Ack and timeout in the same cycle: ack SHALL win, with normal data and mem_err unchanged.
REQ-024 dmem_ack outside WAIT SHALL be ignored.
REQ-025 EX_* changes during WAIT SHALL have no effect.
REQ-026 Back-to-back memory ops SHALL each take the full IDLE→WAIT→DONE sequence; no pipelining of requests.
REQ-027 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be 0 whenever the FSM is not in WAIT.

Reset
REQ-028 While reset is high on an edge: state IDLE; latches, data register, counter and mem_err all 0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the op, drop dmem_req on the next edge, and not complete the op after reset releases; an ack arriving after reset SHALL be ignored.
REQ-030 After reset, combinational outputs SHALL follow REQ-015 from the current EX_* inputs.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/WAIT/DONE), DATA_W=8, RADDR_W=2 and TIMEOUT_LIMIT=15.
REQ-032 The wait counter with limit compare SHALL be the single sub-module mem_wait_timer (inputs clear, enable; output expired).

Verification
REQ-033 ALU op EX_alu_result=0x5A, EX_rd=2, EX_reg_write=1 → same cycle MEM_alu_result=0x5A, MEM_rd=2, MEM_mem_data=0, mem_stall=0.
REQ-034 Load addr 0x10, ack in the 1st WAIT cycle with rdata=0xC3 → stall high for 2 cycles, DONE shows MEM_mem_data=0xC3, MEM_mem_to_reg=1, dmem_req high exactly 1 cycle.
REQ-035 Store addr 0x20, data 0x7E, ack after 3 WAIT cycles → dmem_we=1, dmem_addr=0x20, dmem_wdata=0x7E for 3 cycles; MEM_reg_write=0; mem_err=0.
REQ-036 Load with ack never arriving → 15 WAIT cycles, then DONE with MEM_mem_data=0x00 and mem_err=1, which stays 1 until reset.
REQ-037 Reset pulsed in the 2nd WAIT cycle, then ack the following cycle → dmem_req=0 after the reset edge, FSM in IDLE, no DONE cycle, mem_err=0.
REQ-038 Ack in the 15th WAIT cycle with rdata=0x99 → DONE with MEM_mem_data=0x99 and mem_err=0.
